// File: rtl/cs_window_filter.sv
// Sliding-window comparator-selector filter: Y = (sum + WIN*Xappr) >> SHIFT.
// Define CS_ROUND_EN for round-half-up instead of truncation before the shift.
module cs_window_filter #(
  parameter int DATA_W = 8,
  parameter int WIN    = 9,
  parameter int SHIFT  = 3,
  parameter int OUT_W  = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          X,
  input  logic                       flush,
  output logic [OUT_W-1:0]           Y,
  output logic                       out_valid,
  output logic [$clog2(WIN+1)-1:0]   fill
);

  localparam int FILL_W = $clog2(WIN+1);
  localparam int PTR_W  = $clog2(WIN);
  localparam int SUM_W  = DATA_W + $clog2(WIN);
  localparam int T_W    = SUM_W + 2;
  localparam int CW     = ((T_W > OUT_W) ? T_W : OUT_W) + 1;
  localparam logic [CW-1:0] MAXY = CW'({OUT_W{1'b1}});
`ifdef CS_ROUND_EN
  localparam int BIAS = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
`else
  localparam int BIAS = 0;
`endif

  logic [DATA_W-1:0] mem_q [WIN];
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              pend_q, pend_d;
  logic [OUT_W-1:0]  y_q, y_d;
  logic              ov_q, ov_d;

  logic              accept, full;
  logic [SUM_W-1:0]  avg;
  logic [DATA_W-1:0] xappr;
  logic [CW-1:0]     t_r, q_r;
  logic [OUT_W-1:0]  y_calc;

  assign accept = in_valid & ~flush;
  assign full   = (fill_q == FILL_W'(WIN));
  assign avg    = sum_q / SUM_W'(WIN);

  always_comb begin
    xappr = '0;
    for (int i = 0; i < WIN; i++) begin
      if (SUM_W'(mem_q[i]) <= avg && mem_q[i] > xappr)
        xappr = mem_q[i];
    end
  end

  always_comb begin
    t_r = CW'(sum_q) + CW'(WIN) * CW'(xappr) + CW'(BIAS);
    q_r = t_r >> SHIFT;
    y_calc = (q_r > MAXY) ? MAXY[OUT_W-1:0] : q_r[OUT_W-1:0];
  end

  always_comb begin
    wp_d   = wp_q;
    fill_d = fill_q;
    sum_d  = sum_q;
    pend_d = 1'b0;
    ov_d   = pend_q & ~flush;
    y_d    = (pend_q & ~flush) ? y_calc : y_q;
    if (flush) begin
      wp_d   = '0;
      fill_d = '0;
      sum_d  = '0;
    end else if (accept) begin
      wp_d   = (wp_q == PTR_W'(WIN - 1)) ? '0 : wp_q + 1'b1;
      // once full, the slot being overwritten holds the oldest sample
      sum_d  = sum_q + SUM_W'(X) - (full ? SUM_W'(mem_q[wp_q]) : '0);
      fill_d = full ? fill_q : fill_q + 1'b1;
      pend_d = full | (fill_q == FILL_W'(WIN - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wp_q] <= X;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q   <= '0;
      fill_q <= '0;
      sum_q  <= '0;
      pend_q <= 1'b0;
      y_q    <= '0;
      ov_q   <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      fill_q <= fill_d;
      sum_q  <= sum_d;
      pend_q <= pend_d;
      y_q    <= y_d;
      ov_q   <= ov_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = ov_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_cs_window_filter.sv
// Scoreboard bench for cs_window_filter: four configurations share one stimulus stream.
// Directed hand-computed checks on the default build plus a random sweep against a model.
module tb_cs_window_filter;

`ifdef CS_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] X = '0;

  logic [9:0] y0, y2, y3;
  logic [8:0] y1;
  logic       ov0, ov1, ov2, ov3;
  logic [3:0] fill0, fill1;
  logic [2:0] fill2;
  logic [4:0] fill3;

  always #5 clk = ~clk;

  cs_window_filter u0 (.clk(clk), .reset(reset), .in_valid(in_valid), .X(X),
    .flush(flush), .Y(y0), .out_valid(ov0), .fill(fill0));
  cs_window_filter #(.OUT_W(9)) u1 (.clk(clk), .reset(reset),
    .in_valid(in_valid), .X(X), .flush(flush), .Y(y1), .out_valid(ov1),
    .fill(fill1));
  cs_window_filter #(.WIN(4), .SHIFT(2)) u2 (.clk(clk), .reset(reset),
    .in_valid(in_valid), .X(X), .flush(flush), .Y(y2), .out_valid(ov2),
    .fill(fill2));
  cs_window_filter #(.WIN(16), .SHIFT(4)) u3 (.clk(clk), .reset(reset),
    .in_valid(in_valid), .X(X), .flush(flush), .Y(y3), .out_valid(ov3),
    .fill(fill3));

  typedef struct {
    int cyc;
    int y;
  } exp_t;

  exp_t sq [4][$];
  int   mbuf [4][64];
  int   mwp [4];
  int   mfill [4];
  int   msum [4];
  int   tests = 0;
  int   fails = 0;
  int   ecount = 0;

  always @(posedge clk) ecount++;

  function automatic int win_of(int c);
    case (c)
      2: return 4;
      3: return 16;
      default: return 9;
    endcase
  endfunction

  function automatic int sh_of(int c);
    case (c)
      2: return 2;
      3: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int ow_of(int c);
    return (c == 1) ? 9 : 10;
  endfunction

  function automatic int ref_y(int c);
    int w, avg, xa, t, y, maxy;
    w = win_of(c);
    avg = msum[c] / w;
    xa = 0;
    for (int i = 0; i < w; i++)
      if (mbuf[c][i] <= avg && mbuf[c][i] > xa) xa = mbuf[c][i];
    t = msum[c] + w * xa;
    if (RND && sh_of(c) > 0) t += 1 << (sh_of(c) - 1);
    y = t >> sh_of(c);
    maxy = (1 << ow_of(c)) - 1;
    return (y > maxy) ? maxy : y;
  endfunction

  task automatic model_clear(int c);
    mwp[c] = 0;
    mfill[c] = 0;
    msum[c] = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(bit v, int x, bit f);
    int n;
    in_valid = v;
    X = 8'(x);
    flush = f;
    n = ecount + 1;
    for (int c = 0; c < 4; c++) begin
      if (f) begin
        while (sq[c].size() > 0 && sq[c][sq[c].size()-1].cyc == n)
          void'(sq[c].pop_back());
        model_clear(c);
      end else if (v) begin
        if (mfill[c] < win_of(c)) begin
          msum[c] += x;
          mfill[c]++;
        end else begin
          msum[c] += x - mbuf[c][mwp[c]];
        end
        mbuf[c][mwp[c]] = x;
        mwp[c] = (mwp[c] + 1) % win_of(c);
        if (mfill[c] == win_of(c)) sq[c].push_back('{n + 1, ref_y(c)});
      end
    end
    @(negedge clk);
  endtask

  task automatic mon(int c, bit ov, int y);
    exp_t e;
    if (ov) begin
      tests++;
      if (sq[c].size() == 0 || sq[c][0].cyc != ecount) begin
        fails++;
        $display("FAIL unexpected_pulse u%0d: got Y=%0d at edge %0d, none due",
                 c, y, ecount);
      end else begin
        e = sq[c].pop_front();
        if (y != e.y) begin
          fails++;
          $display("FAIL y_u%0d: got %0d expected %0d", c, y, e.y);
        end
      end
    end else if (sq[c].size() > 0 && sq[c][0].cyc <= ecount) begin
      tests++;
      fails++;
      e = sq[c].pop_front();
      $display("FAIL missed_pulse u%0d: got no pulse expected Y=%0d", c, e.y);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, ov0, int'(y0));
      mon(1, ov1, int'(y1));
      mon(2, ov2, int'(y2));
      mon(3, ov3, int'(y3));
    end
  end

  task automatic async_reset();
    in_valid = 1'b0;
    flush = 1'b0;
    #2 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      model_clear(c);
      sq[c].delete();
    end
    #1;
    chk("async_rst_y", int'(y0), 0);
    chk("async_rst_ov", int'(ov0), 0);
    chk("async_rst_fill", int'(fill0), 0);
    chk("async_rst_fill_w16", int'(fill3), 0);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < 4; c++) model_clear(c);
    #2;
    chk("reset_y", int'(y0), 0);
    chk("reset_ov", int'(ov0), 0);
    chk("reset_fill", int'(fill0), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 1; i <= 9; i++) begin
      step(1'b1, i, 1'b0);
      chk($sformatf("fill_%0d", i), int'(fill0), i);
    end
    step(1'b0, 0, 1'b0);
    chk("ramp_ov", int'(ov0), 1);
    chk("ramp_y", int'(y0), 11);
    step(1'b1, 10, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("ramp_next_y", int'(y0), RND ? 14 : 13);

    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 255, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("max_y", int'(y0), RND ? 574 : 573);
    chk("sat_y", int'(y1), 511);

    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b0);
    step(1'b1, 200, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("spike_y", int'(y0), 25);
    step(1'b1, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("evict_y", int'(y0), 25);

    step(1'b1, 100, 1'b0);
    chk("gap_ov_accept", int'(ov0), 0);
    step(1'b0, 0, 1'b0);
    chk("gap_ov_pulse", int'(ov0), 1);
    chk("gap_y", int'(y0), RND ? 38 : 37);
    step(1'b0, 0, 1'b0);
    chk("gap_ov_idle", int'(ov0), 0);
    chk("gap_y_hold", int'(y0), RND ? 38 : 37);
    step(1'b1, 50, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("gap_y2", int'(y0), RND ? 44 : 43);

    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 10 + i, 1'b0);
    step(1'b1, 99, 1'b1);
    chk("flush_fill", int'(fill0), 0);
    chk("flush_ov", int'(ov0), 0);
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0);
    chk("refill_ov", int'(ov0), 0);
    chk("refill_fill", int'(fill0), 8);
    step(1'b1, 9, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("refill_pulse", int'(ov0), 1);
    chk("refill_y", int'(y0), 11);

    for (int i = 0; i < 5; i++) step(1'b1, 30 * i, 1'b0);
    async_reset();
    step(1'b1, 7, 1'b0);
    chk("post_rst_fill", int'(fill0), 1);

    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) async_reset();
      step($urandom_range(0, 99) < 80, int'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 2);
    end

    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);
    for (int c = 0; c < 4; c++)
      chk($sformatf("drain_u%0d", c), sq[c].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
